midi_note_parser: RTL and testbench

Monophonic MIDI channel-voice parser that sits directly upstream of the note-to-counter-period stage. Consumes a byte stream from the UART receiver and decodes Note On / Note Off / All Notes Off for one channel, handling running status and interleaved real-time bytes. Outputs a registered 7-bit MIDI note number, velocity and gate. `note_o` feeds the period converter's `note_i` directly; `gate_o` enables the oscillator.

---
 rtl/midi_note_parser.sv | 108 ++++++++++
 tb/tb_midi_note_parser.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/midi_note_parser.sv
// Monophonic MIDI channel-voice parser: Note On / Note Off / All Notes Off
// for one channel (or all channels when OMNI is set). It handles running
// status and discards real-time bytes wherever they appear.
module midi_note_parser #(
  parameter logic [3:0] CHANNEL = 4'd0,
  parameter bit         OMNI    = 1'b0
) (
  input  logic       clk_i,
  input  logic       nrst_i,
  input  logic [7:0] rxData_i,
  input  logic       rxValid_i,
  output logic [7:0] note_o,
  output logic [6:0] velocity_o,
  output logic       gate_o,
  output logic       noteValid_o
);

  typedef enum logic [1:0] {IDLE, DATA1, DATA2} state_t;

  state_t     state;
  logic [7:0] run_stat;
  logic [6:0] d1;

  logic       is_rt, is_sys, is_stat, is_data;
  logic       one_byte, done, chan_ok, changed;
  logic [6:0] key, val;
  logic [7:0] nxt_note;
  logic [6:0] nxt_vel;
  logic       nxt_gate;

  // Classify the incoming byte and work out the message result when this byte completes a message
  always_comb begin
    is_rt    = (rxData_i[7:3] == 5'b11111);
    is_sys   = (rxData_i[7:4] == 4'hF) && !is_rt;
    is_stat  = rxData_i[7] && (rxData_i[7:4] != 4'hF);
    is_data  = !rxData_i[7];
    one_byte = (run_stat[7:4] == 4'hC) || (run_stat[7:4] == 4'hD);
    done     = rxValid_i && is_data &&
               ((state == DATA2) || ((state == DATA1) && one_byte));
    chan_ok  = OMNI || (run_stat[3:0] == CHANNEL);
    // Single-byte messages complete in DATA1, so that byte acts as the first data byte
    key      = (state == DATA2) ? d1 : rxData_i[6:0];
    val      = (state == DATA2) ? rxData_i[6:0] : '0;

    nxt_note = note_o;
    nxt_vel  = velocity_o;
    nxt_gate = gate_o;
    case (run_stat[7:4])
      4'h9: begin
        if (val != '0) begin
          nxt_note = {1'b0, key};
          nxt_vel  = val;
          nxt_gate = 1'b1;
        end else if (key == note_o[6:0]) begin
          nxt_gate = 1'b0;
        end
      end
      4'h8: begin
        if (key == note_o[6:0]) nxt_gate = 1'b0;
      end
      4'hB: begin
        if (key == 7'd123) nxt_gate = 1'b0;
      end
      default: ;
    endcase
    changed = (nxt_note != note_o) || (nxt_vel != velocity_o) || (nxt_gate != gate_o);
  end

  // Parser FSM, running-status register and registered voice outputs
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state       <= IDLE;
      run_stat    <= '0;
      d1          <= '0;
      note_o      <= '0;
      velocity_o  <= '0;
      gate_o      <= 1'b0;
      noteValid_o <= 1'b0;
    end else begin
      noteValid_o <= 1'b0;
      if (rxValid_i && !is_rt) begin
        if (is_sys) begin
          run_stat <= '0;
          state    <= IDLE;
        end else if (is_stat) begin
          run_stat <= rxData_i;
          state    <= DATA1;
        end else begin
          case (state)
            DATA1: begin
              d1 <= rxData_i[6:0];
              if (!one_byte) state <= DATA2;
            end
            DATA2:   state <= DATA1;
            default: ;
          endcase
        end
      end
      if (done && chan_ok) begin
        note_o      <= nxt_note;
        velocity_o  <= nxt_vel;
        gate_o      <= nxt_gate;
        noteValid_o <= changed;
      end
    end
  end

endmodule

// File: tb/tb_midi_note_parser.sv
// Self-checking bench for midi_note_parser. Directed scenarios come first,
// then a randomized byte stream checked against a queue-based reference.
module tb_midi_note_parser;

  localparam logic [3:0] CH = 4'd0;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] note;
  logic [6:0] vel;
  logic       gate;
  logic       nvalid;

  int n_cmp = 0;
  int n_err = 0;
  int dut_str = 0;

  // reference model state
  logic [7:0] m_rs;
  logic [6:0] mq[$];
  logic [7:0] m_note;
  logic [6:0] m_vel;
  logic       m_gate;
  logic       m_pulse;

  midi_note_parser #(.CHANNEL(CH), .OMNI(1'b0)) dut (
    .clk_i(clk), .nrst_i(nrst), .rxData_i(rx_data), .rxValid_i(rx_valid),
    .note_o(note), .velocity_o(vel), .gate_o(gate), .noteValid_o(nvalid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (nvalid === 1'b1) dut_str++;

  task automatic model_reset();
    m_rs = '0; mq.delete();
    m_note = '0; m_vel = '0; m_gate = 1'b0; m_pulse = 1'b0;
  endtask

  task automatic model_apply(input logic [7:0] st, input logic [6:0] a, input logic [6:0] b);
    logic [7:0] o_n; logic [6:0] o_v; logic o_g;
    o_n = m_note; o_v = m_vel; o_g = m_gate;
    if (st[3:0] != CH) return;
    if (st[7:4] == 4'h9 && b != 0) begin
      m_note = {1'b0, a}; m_vel = b; m_gate = 1'b1;
    end else if ((st[7:4] == 4'h8 || st[7:4] == 4'h9) && m_gate && a == m_note[6:0]) begin
      m_gate = 1'b0;
    end else if (st[7:4] == 4'hB && a == 7'd123) begin
      m_gate = 1'b0;
    end
    m_pulse = (o_n != m_note) || (o_v != m_vel) || (o_g != m_gate);
  endtask

  task automatic model_byte(input logic [7:0] b);
    int need;
    m_pulse = 1'b0;
    if (b >= 8'hF8) return;
    if (b >= 8'hF0) begin m_rs = '0; mq.delete(); return; end
    if (b[7]) begin m_rs = b; mq.delete(); return; end
    if (m_rs == 0) return;
    mq.push_back(b[6:0]);
    need = (m_rs[7:4] == 4'hC || m_rs[7:4] == 4'hD) ? 1 : 2;
    if (mq.size() == need) begin
      model_apply(m_rs, mq[0], (need == 2) ? mq[1] : 7'd0);
      mq.delete();
    end
  endtask

  // Drives one byte for one cycle; returns #1 after the sampling edge
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk);
    model_byte(b);
    #1;
  endtask

  task automatic idle_cycle(input logic [7:0] junk);
    @(negedge clk);
    rx_data = junk; rx_valid = 1'b0;
    @(posedge clk);
    m_pulse = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0; nrst = 1'b0;
    model_reset();
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    nrst = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (note !== 8'h00) begin n_err++; $display("FAIL reset_note got %h want 00", note); end
    n_cmp++; if (vel !== 7'h00) begin n_err++; $display("FAIL reset_vel got %h want 00", vel); end
    n_cmp++; if (gate !== 1'b0) begin n_err++; $display("FAIL reset_gate got %b want 0", gate); end
    n_cmp++; if (nvalid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", nvalid); end
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_note_on();
    int s0;
    do_reset();
    s0 = dut_str;
    send_byte(8'h90); send_byte(8'h45); send_byte(8'h64);
    n_cmp++; if (nvalid !== 1'b1) begin n_err++; $display("FAIL noteon_pulse got %b want 1", nvalid); end
    idle_cycle(8'h00);
    n_cmp++; if (note !== 8'h45) begin n_err++; $display("FAIL noteon_note got %h want 45", note); end
    n_cmp++; if (vel !== 7'd100) begin n_err++; $display("FAIL noteon_vel got %0d want 100", vel); end
    n_cmp++; if (gate !== 1'b1) begin n_err++; $display("FAIL noteon_gate got %b want 1", gate); end
    n_cmp++; if (dut_str - s0 != 1) begin n_err++; $display("FAIL noteon_strobes got %0d want 1", dut_str - s0); end
  endtask

  task automatic test_running_status();
    int s0;
    do_reset();
    s0 = dut_str;
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h40);
    n_cmp++; if (note !== 8'h3C || gate !== 1'b1) begin n_err++; $display("FAIL rs_first got %h/%b want 3c/1", note, gate); end
    send_byte(8'h40); send_byte(8'h40);
    n_cmp++; if (note !== 8'h40 || gate !== 1'b1) begin n_err++; $display("FAIL rs_second got %h/%b want 40/1", note, gate); end
    send_byte(8'h40); send_byte(8'h00);
    idle_cycle(8'h00);
    n_cmp++; if (gate !== 1'b0) begin n_err++; $display("FAIL rs_off_gate got %b want 0", gate); end
    n_cmp++; if (note !== 8'h40) begin n_err++; $display("FAIL rs_off_note got %h want 40", note); end
    n_cmp++; if (dut_str - s0 != 3) begin n_err++; $display("FAIL rs_strobes got %0d want 3", dut_str - s0); end
  endtask

  task automatic test_mismatch_off();
    int s0;
    do_reset();
    send_byte(8'h90); send_byte(8'h45); send_byte(8'h64);
    idle_cycle(8'h00);
    s0 = dut_str;
    send_byte(8'h80); send_byte(8'h30); send_byte(8'h00);
    idle_cycle(8'h00);
    n_cmp++; if (gate !== 1'b1) begin n_err++; $display("FAIL off_wrong_gate got %b want 1", gate); end
    n_cmp++; if (dut_str != s0) begin n_err++; $display("FAIL off_wrong_strobes got %0d want 0", dut_str - s0); end
    send_byte(8'h80); send_byte(8'h45); send_byte(8'h00);
    idle_cycle(8'h00);
    n_cmp++; if (gate !== 1'b0) begin n_err++; $display("FAIL off_match_gate got %b want 0", gate); end
    n_cmp++; if (note !== 8'h45 || vel !== 7'd100) begin n_err++; $display("FAIL off_match_hold got %h/%0d want 45/100", note, vel); end
    n_cmp++; if (dut_str - s0 != 1) begin n_err++; $display("FAIL off_match_strobes got %0d want 1", dut_str - s0); end
  endtask

  task automatic test_back_to_back_realtime();
    int s0;
    do_reset();
    s0 = dut_str;
    send_byte(8'h90); send_byte(8'hF8); send_byte(8'h50); send_byte(8'hFE); send_byte(8'h7F);
    idle_cycle(8'h00);
    n_cmp++; if (note !== 8'h50 || vel !== 7'd127 || gate !== 1'b1)
      begin n_err++; $display("FAIL rt_note got %h/%0d/%b want 50/127/1", note, vel, gate); end
    n_cmp++; if (dut_str - s0 != 1) begin n_err++; $display("FAIL rt_strobes got %0d want 1", dut_str - s0); end
    send_byte(8'hB0); send_byte(8'h7B); send_byte(8'h00);
    idle_cycle(8'h00);
    n_cmp++; if (gate !== 1'b0) begin n_err++; $display("FAIL allnotesoff_gate got %b want 0", gate); end
  endtask

  task automatic test_filter();
    int s0;
    logic [7:0] seq[11] = '{8'h91, 8'h50, 8'h40, 8'hC0, 8'h05, 8'h50, 8'h40,
                            8'hF0, 8'h41, 8'h42, 8'hF7};
    do_reset();
    s0 = dut_str;
    foreach (seq[i]) send_byte(seq[i]);
    send_byte(8'h50); send_byte(8'h40);
    idle_cycle(8'h00);
    n_cmp++; if (note !== 8'h00 || vel !== 7'h00 || gate !== 1'b0)
      begin n_err++; $display("FAIL filter_outputs got %h/%0d/%b want 00/0/0", note, vel, gate); end
    n_cmp++; if (dut_str != s0) begin n_err++; $display("FAIL filter_strobes got %0d want 0", dut_str - s0); end
  endtask

  task automatic test_reset_mid_message();
    do_reset();
    send_byte(8'h90); send_byte(8'h45); send_byte(8'h64);
    send_byte(8'h90); send_byte(8'h45);
    @(negedge clk);
    rx_valid = 1'b0; nrst = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (note !== 8'h00 || vel !== 7'h00 || gate !== 1'b0 || nvalid !== 1'b0)
      begin n_err++; $display("FAIL midreset_outputs got %h/%0d/%b/%b want 0/0/0/0", note, vel, gate, nvalid); end
    @(negedge clk);
    nrst = 1'b1;
    send_byte(8'h64);
    n_cmp++; if (nvalid !== 1'b0 || gate !== 1'b0) begin n_err++; $display("FAIL midreset_stray got %b/%b want 0/0", nvalid, gate); end
    send_byte(8'h90); send_byte(8'h30); send_byte(8'h20);
    n_cmp++; if (note !== 8'h30 || vel !== 7'd32 || gate !== 1'b1)
      begin n_err++; $display("FAIL midreset_final got %h/%0d/%b want 30/32/1", note, vel, gate); end
  endtask

  function automatic logic [7:0] rand_byte();
    int unsigned r;
    logic [3:0] hi[7] = '{4'h9, 4'h9, 4'h8, 4'hB, 4'hC, 4'hD, 4'hE};
    logic [7:0] dv[7] = '{8'h40, 8'h41, 8'h42, 8'h00, 8'h7F, 8'h01, 8'd123};
    r = $urandom_range(0, 99);
    if (r < 12) return {hi[$urandom_range(0, 6)], ($urandom_range(0, 3) == 0) ? 4'd1 : 4'd0};
    if (r < 18) return 8'hF8 + 8'($urandom_range(0, 7));
    if (r < 21) return 8'hF0 + 8'($urandom_range(0, 7));
    return dv[$urandom_range(0, 6)];
  endfunction

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) idle_cycle(rand_byte());
      else send_byte(rand_byte());
      n_cmp++; if (note !== m_note) begin n_err++; $display("FAIL rand_note step %0d got %h want %h", i, note, m_note); end
      n_cmp++; if (vel !== m_vel) begin n_err++; $display("FAIL rand_vel step %0d got %h want %h", i, vel, m_vel); end
      n_cmp++; if (gate !== m_gate) begin n_err++; $display("FAIL rand_gate step %0d got %b want %b", i, gate, m_gate); end
      n_cmp++; if (nvalid !== m_pulse) begin n_err++; $display("FAIL rand_valid step %0d got %b want %b", i, nvalid, m_pulse); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_note_on();
    test_running_status();
    test_mismatch_off();
    test_back_to_back_realtime();
    test_filter();
    test_reset_mid_message();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
